// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C command sequencer: mode codes, controller idle code,
// sequencer state encoding and the packed command layout held in the FIFO.
package i2c_pkg;

  localparam logic I2C_READ  = 1'b0;
  localparam logic I2C_WRITE = 1'b1;

  localparam logic [3:0] I2C_ST_IDLE = 4'd0;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_ISSUE = 2'd1,
    SEQ_WAIT  = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic       mode;
    logic [6:0] addr;
    logic [7:0] data;
  } i2c_cmd_t;

  localparam int unsigned CMD_W = $bits(i2c_cmd_t);

endpackage

// File: rtl/i2c_cmd_sequencer_fifo.sv
// Synchronous FIFO with occupancy count. Pointers wrap naturally because DEPTH is a power of two.
module sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q, count_d;
  logic             push, pop;

  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign push      = wr_en_i && !full_o;
  assign pop       = rd_en_i && !empty_o;
  assign rd_data_o = mem_q[rptr_q];
  assign count_o   = count_q;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Feeds queued I2C commands one at a time to the I2C controller, tracks completion through the
// controller state, returns read bytes and bounds every transaction with a timeout.
module i2c_cmd_sequencer
  import i2c_pkg::*;
#(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic                   cmd_mode_i,
  input  logic [6:0]             cmd_addr_i,
  input  logic [7:0]             cmd_data_i,
  output logic                   rd_valid_o,
  output logic [7:0]             rd_data_o,
  output logic                   done_o,
  output logic                   timeout_err_o,
  output logic                   busy_o,
  output logic [$clog2(DEPTH):0] fifo_count_o,
  output logic                   i2c_enable_o,
  output logic                   i2c_mode_o,
  output logic [6:0]             i2c_addr_o,
  output logic [7:0]             i2c_tx_byte_o,
  input  logic [3:0]             i2c_state_i,
  input  logic [7:0]             i2c_byte_i
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  seq_state_e       state_q, state_d;
  i2c_cmd_t         cmd_q, cmd_d, head_cmd, in_cmd;
  logic [CMD_W-1:0] head_raw;
  logic [TW-1:0]    cnt_q, cnt_d;
  logic             en_q, en_d, done_q, done_d, terr_q, terr_d, rdv_q, rdv_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             pop, fifo_full, fifo_empty, ctrl_idle, timed_out;

  assign in_cmd = '{mode: cmd_mode_i, addr: cmd_addr_i, data: cmd_data_i};

  sync_fifo #(
    .WIDTH(CMD_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en_i  (cmd_valid_i),
    .wr_data_i(in_cmd),
    .rd_en_i  (pop),
    .rd_data_o(head_raw),
    .count_o  (fifo_count_o),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  assign head_cmd  = i2c_cmd_t'(head_raw);
  assign ctrl_idle = (i2c_state_i == I2C_ST_IDLE);
  assign timed_out = (cnt_q == TMAX);

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    done_d  = 1'b0;
    terr_d  = 1'b0;
    rdv_d   = 1'b0;
    rdata_d = rdata_q;
    pop     = 1'b0;
    unique case (state_q)
      SEQ_IDLE: begin
        if (!fifo_empty && ctrl_idle) begin
          pop     = 1'b1;
          cmd_d   = head_cmd;
          cnt_d   = '0;
          en_d    = 1'b1;
          state_d = SEQ_ISSUE;
        end
      end
      SEQ_ISSUE: begin
        cnt_d = cnt_q + 1'b1;
        if (timed_out) begin
          en_d    = 1'b0;
          done_d  = 1'b1;
          terr_d  = 1'b1;
          state_d = SEQ_IDLE;
        end else if (!ctrl_idle) begin
          en_d    = 1'b0;
          state_d = SEQ_WAIT;
        end
      end
      SEQ_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // Controller returning to idle wins over a coincident timeout.
        if (ctrl_idle) begin
          done_d  = 1'b1;
          state_d = SEQ_IDLE;
          if (cmd_q.mode == I2C_READ) begin
            rdv_d   = 1'b1;
            rdata_d = i2c_byte_i;
          end
        end else if (timed_out) begin
          en_d    = 1'b0;
          done_d  = 1'b1;
          terr_d  = 1'b1;
          state_d = SEQ_IDLE;
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SEQ_IDLE;
      cmd_q   <= '0;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      terr_q  <= 1'b0;
      rdv_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      done_q  <= done_d;
      terr_q  <= terr_d;
      rdv_q   <= rdv_d;
      rdata_q <= rdata_d;
    end
  end

  assign cmd_ready_o   = !fifo_full;
  assign busy_o        = (state_q != SEQ_IDLE) || !fifo_empty;
  assign rd_valid_o    = rdv_q;
  assign rd_data_o     = rdata_q;
  assign done_o        = done_q;
  assign timeout_err_o = terr_q;
  assign i2c_enable_o  = en_q;
  assign i2c_mode_o    = cmd_q.mode;
  assign i2c_addr_o    = cmd_q.addr;
  assign i2c_tx_byte_o = cmd_q.data;

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Directed bench for i2c_cmd_sequencer with a behavioural I2C controller model that samples
// enable every 4 clocks; a second instance with a short timeout covers the timeout path.
module tb_i2c_cmd_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       cmd_valid, cmd_valid_t, cmd_mode;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_data;

  logic       cmd_ready, rd_valid, done, timeout_err, busy, i2c_enable, i2c_mode;
  logic [7:0] rd_data, i2c_tx_byte;
  logic [6:0] i2c_addr;
  logic [2:0] fifo_count;

  logic       cmd_ready_t, rd_valid_t, done_t, timeout_err_t, busy_t, i2c_enable_t, i2c_mode_t;
  logic [7:0] rd_data_t, i2c_tx_byte_t;
  logic [6:0] i2c_addr_t;
  logic [2:0] fifo_count_t;

  // Controller model
  logic [3:0] st_m;
  logic [7:0] byte_m, model_byte;
  logic [1:0] div_m;
  int         rem_m, run_len;
  logic [15:0] cap_m;

  i2c_cmd_sequencer #(.DEPTH(4), .TIMEOUT_CYCLES(1024)) dut (
    .clk(clk), .reset(reset), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_mode_i(cmd_mode), .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data),
    .rd_valid_o(rd_valid), .rd_data_o(rd_data), .done_o(done), .timeout_err_o(timeout_err),
    .busy_o(busy), .fifo_count_o(fifo_count), .i2c_enable_o(i2c_enable), .i2c_mode_o(i2c_mode),
    .i2c_addr_o(i2c_addr), .i2c_tx_byte_o(i2c_tx_byte), .i2c_state_i(st_m), .i2c_byte_i(byte_m)
  );

  i2c_cmd_sequencer #(.DEPTH(4), .TIMEOUT_CYCLES(16)) dut_to (
    .clk(clk), .reset(reset), .cmd_valid_i(cmd_valid_t), .cmd_ready_o(cmd_ready_t),
    .cmd_mode_i(cmd_mode), .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data),
    .rd_valid_o(rd_valid_t), .rd_data_o(rd_data_t), .done_o(done_t),
    .timeout_err_o(timeout_err_t), .busy_o(busy_t), .fifo_count_o(fifo_count_t),
    .i2c_enable_o(i2c_enable_t), .i2c_mode_o(i2c_mode_t), .i2c_addr_o(i2c_addr_t),
    .i2c_tx_byte_o(i2c_tx_byte_t), .i2c_state_i(4'd0), .i2c_byte_i(8'd0)
  );

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      st_m <= 4'd0; div_m <= 2'd0; rem_m <= 0; byte_m <= 8'd0; cap_m <= 16'd0;
    end else begin
      div_m <= div_m + 2'd1;
      if (st_m == 4'd0) begin
        if (div_m == 2'd3 && i2c_enable) begin
          st_m  <= 4'd5;
          rem_m <= run_len;
          cap_m <= {i2c_mode, i2c_addr, i2c_tx_byte};
        end
      end else if (rem_m <= 1) begin
        st_m   <= 4'd0;
        byte_m <= model_byte;
      end else begin
        rem_m <= rem_m - 1;
      end
    end
  end

  // Monitor: pulse counters, completion log and operand stability while the controller runs
  int         done_cnt = 0, rdv_cnt = 0, unstable = 0;
  logic [6:0] log_q[$];
  always @(negedge clk) begin
    if (!reset) begin
      if (done) begin
        done_cnt++;
        log_q.push_back(i2c_addr);
      end
      if (rd_valid) rdv_cnt++;
      if (st_m != 4'd0 && {i2c_mode, i2c_addr, i2c_tx_byte} !== cap_m) unstable++;
    end
  end

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_cmd(input logic m, input logic [6:0] a, input logic [7:0] d,
                          output logic acc);
    cmd_valid = 1'b1; cmd_mode = m; cmd_addr = a; cmd_data = d;
    acc = cmd_ready;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int max, input string tag);
    logic got = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    chk(tag, got, 1);
  endtask

  task automatic wait_model(input int max, input string tag);
    logic got = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (st_m != 4'd0) begin
        got = 1'b1;
        break;
      end
    end
    chk(tag, got, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic       acc, got;
  int         d0, r0, cyc;
  logic [6:0] exp_log [5];

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_valid_t = 1'b0;
    cmd_mode = 1'b0; cmd_addr = 7'd0; cmd_data = 8'd0; run_len = 90; model_byte = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_enable", i2c_enable, 0);
    chk("rst_outs", {done, timeout_err, rd_valid, rd_data, i2c_mode, i2c_addr, i2c_tx_byte}, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Write transaction
    d0 = done_cnt; r0 = rdv_cnt;
    push_cmd(1'b1, 7'h1A, 8'h34, acc);
    chk("wr_accept", acc, 1);
    chk("wr_busy", busy, 1);
    @(posedge clk); #1;
    chk("wr_enable_after_pop", i2c_enable, 1);
    wait_done(300, "wr_done_seen");
    chk("wr_no_terr", timeout_err, 0);
    chk("wr_operands", {i2c_mode, i2c_addr, i2c_tx_byte}, {1'b1, 7'h1A, 8'h34});
    repeat (3) @(negedge clk);
    chk("wr_done_count", done_cnt - d0, 1);
    chk("wr_no_rd_valid", rdv_cnt - r0, 0);
    chk("wr_stable", unstable, 0);

    // Read transaction
    run_len = 30; model_byte = 8'hA5;
    push_cmd(1'b0, 7'h1A, 8'h00, acc);
    wait_done(200, "rd_done_seen");
    chk("rd_valid_with_done", rd_valid, 1);
    chk("rd_data", rd_data, 8'hA5);
    @(negedge clk);
    chk("rd_valid_pulse", rd_valid, 0);
    chk("rd_data_hold", rd_data, 8'hA5);

    // Fill while busy, then push against a simultaneous pop at full
    run_len = 40; log_q.delete(); d0 = done_cnt;
    push_cmd(1'b1, 7'h10, 8'h01, acc);
    wait_model(20, "fill_model_start");
    for (int i = 0; i < 5; i++) begin
      push_cmd(1'b1, 7'(8'h21 + i), 8'(8'h50 + i), acc);
      chk("fill_accept", acc, (i < 4) ? 1 : 0);
    end
    chk("fill_count", fifo_count, 4);
    chk("fill_ready_low", cmd_ready, 0);
    wait_done(200, "fill_first_done");
    push_cmd(1'b1, 7'h26, 8'h66, acc);
    chk("full_pop_push_refused", acc, 0);
    chk("full_pop_count", fifo_count, 3);
    chk("gap_enable", i2c_enable, 1);
    chk("gap_addr", i2c_addr, 7'h21);
    for (int i = 0; i < 4; i++) wait_done(200, "fill_done_seen");
    repeat (3) @(negedge clk);
    chk("fill_done_count", done_cnt - d0, 5);
    chk("fill_log_size", log_q.size(), 5);
    exp_log = '{7'h10, 7'h21, 7'h22, 7'h23, 7'h24};
    for (int i = 0; i < 5; i++) begin
      if (i < log_q.size()) chk("fill_order", log_q[i], exp_log[i]);
    end
    chk("fill_stable", unstable, 0);

    // Timeout on the short-timeout instance whose controller never leaves idle
    cmd_mode = 1'b1; cmd_addr = 7'h40; cmd_data = 8'h11; cmd_valid_t = 1'b1;
    @(posedge clk); #1 cmd_addr = 7'h41;
    @(posedge clk); #1 cmd_valid_t = 1'b0;
    chk("to_enable", i2c_enable_t, 1);
    chk("to_count", fifo_count_t, 1);
    cyc = 0; got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (done_t) begin
        got = 1'b1;
        break;
      end
    end
    chk("to_done_seen", got, 1);
    chk("to_cycles", cyc, 16);
    chk("to_terr", timeout_err_t, 1);
    chk("to_enable_low", i2c_enable_t, 0);
    chk("to_no_rd_valid", rd_valid_t, 0);
    @(posedge clk); #1;
    chk("to_next_issued", {i2c_enable_t, i2c_addr_t}, {1'b1, 7'h41});
    chk("to_pulse_end", {done_t, timeout_err_t}, 0);

    // Reset while waiting on the controller with two commands queued
    run_len = 60;
    push_cmd(1'b1, 7'h31, 8'h01, acc);
    push_cmd(1'b1, 7'h32, 8'h02, acc);
    push_cmd(1'b1, 7'h33, 8'h03, acc);
    wait_model(20, "rst_model_start");
    repeat (3) @(negedge clk);
    chk("pre_rst_count", fifo_count, 2);
    chk("pre_rst_wait", {busy, i2c_enable}, 2'b10);
    @(posedge clk); #1 reset = 1'b1;
    #1;
    chk("mid_rst_enable", i2c_enable, 0);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_ready_busy", {cmd_ready, busy}, 2'b10);
    chk("mid_rst_outs", {done, timeout_err, rd_valid, rd_data, i2c_addr, i2c_tx_byte}, 0);
    chk("mid_rst_to_enable", i2c_enable_t, 0);
    @(posedge clk); #1 reset = 1'b0;
    d0 = done_cnt;
    repeat (100) @(negedge clk);
    chk("post_rst_no_done", done_cnt - d0, 0);
    chk("post_rst_idle", {i2c_enable, busy, fifo_count}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
